// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the default data width, the RX FIFO depth, and the status register
// bit positions that the APB register block uses to expose FIFO state.
package uart_pkg;

  localparam int UART_DBIT         = 8;
  localparam int UART_RXFIFO_DEPTH = 16;

  // Status register bit positions
  localparam int STAT_RXNE   = 0;  // RX FIFO not empty
  localparam int STAT_RXFULL = 1;  // RX FIFO full
  localparam int STAT_OVR    = 2;  // sticky RX overrun

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DBIT register array for the UART FIFOs.
// The write port is synchronous. The read port is asynchronous, so the
// entry at raddr is visible in the same cycle (first-word fall-through).
// There is no reset because the contents are only meaningful under the
// owner's pointers.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module uart_fifo_mem #(
  parameter  int DEPTH = 16,
  parameter  int DBIT  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DBIT-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DBIT-1:0] rdata
);

  logic [DBIT-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: a first-word-fall-through FIFO.
// It captures each byte that the receiver strobes in with i_rx_done_tick.
// The register block drains it with i_pop.
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   i_rx_done_tick - byte valid on i_rx_data this cycle
//   i_rx_data      - received byte
//   i_pop          - drop the head entry (ignored when empty)
//   i_flush        - empty the FIFO; beats push/pop in the same cycle
//   i_ovr_clr      - clear the sticky overrun flag
//   i_thresh       - occupancy interrupt threshold; 0 disables it
//   o_rd_data      - head entry, meaningful only when !o_empty
//   o_empty/o_full - occupancy flags
//   o_count        - occupancy, 0..DEPTH
//   o_overrun      - sticky flag: a byte was dropped on a full FIFO
//   o_irq_thresh   - level interrupt: count >= i_thresh (i_thresh != 0)
//   o_irq_ovr      - one-cycle pulse when o_overrun rises
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RXFIFO_DEPTH,
  parameter  int DBIT  = UART_DBIT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rx_done_tick,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic            i_ovr_clr,
  input  logic [AW:0]     i_thresh,
  output logic [DBIT-1:0] o_rd_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [AW:0]     o_count,
  output logic            o_overrun,
  output logic            o_irq_thresh,
  output logic            o_irq_ovr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overrun, irq_ovr;
  logic          empty, full, pop_ok, push_ok, drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is popped. The flush discards the push, so the push is gated here
  // and the memory never sees it.
  assign pop_ok  = i_pop & ~empty;
  assign push_ok = i_rx_done_tick & (~full | pop_ok) & ~i_flush;
  // A byte flushed away is not an overrun. Only a real lack of space counts.
  assign drop    = i_rx_done_tick & full & ~pop_ok & ~i_flush;

  uart_fifo_mem #(.DEPTH(DEPTH), .DBIT(DBIT)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (i_rx_data),
    .raddr (rd_ptr),
    .rdata (o_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // If a drop and a clear happen in the same cycle, the set wins. The pulse
  // fires only on a 0->1 edge of the flag, so a repeat drop stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      irq_ovr <= 1'b0;
    end else begin
      overrun <= drop | (overrun & ~i_ovr_clr);
      irq_ovr <= drop & ~overrun;
    end
  end

  assign o_empty      = empty;
  assign o_full       = full;
  assign o_count      = count;
  assign o_overrun    = overrun;
  assign o_irq_ovr    = irq_ovr;
  assign o_irq_thresh = (i_thresh != '0) && (count >= i_thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. It uses a queue reference model and
// hand-computed checkpoints.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] din;
  logic       pop, flush, ovr_clr;
  logic [4:0] thresh;
  logic [7:0] rd_data;
  logic       empty, full, overrun, irq_thresh, irq_ovr;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         m_ovr, m_irq;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_done_tick (tick),
    .i_rx_data      (din),
    .i_pop          (pop),
    .i_flush        (flush),
    .i_ovr_clr      (ovr_clr),
    .i_thresh       (thresh),
    .o_rd_data      (rd_data),
    .o_empty        (empty),
    .o_full         (full),
    .o_count        (count),
    .o_overrun      (overrun),
    .o_irq_thresh   (irq_thresh),
    .o_irq_ovr      (irq_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("m_cnt",   32'(count), 32'(q.size()));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full",  32'(full),  32'(q.size() == 16));
    chk("m_ovr",   32'(overrun), 32'(m_ovr));
    chk("m_irqovr", 32'(irq_ovr), 32'(m_irq));
    chk("m_thr",   32'(irq_thresh), 32'(thresh != 0 && q.size() >= int'(thresh)));
    if (q.size() > 0) chk("m_head", 32'(rd_data), 32'(q[0]));
  endtask

  // One clock: drive the inputs, advance the model, then sample #1 after the edge.
  task automatic cyc(input bit tk, input logic [7:0] d, input bit pp, input bit fl, input bit cl);
    int  n;
    bit  popok, drp;
    tick = tk; din = d; pop = pp; flush = fl; ovr_clr = cl;
    n     = q.size();
    popok = pp && n > 0;
    drp   = tk && n == 16 && !popok && !fl;
    m_irq = drp && !m_ovr;
    m_ovr = drp || (m_ovr && !cl);
    if (fl) q.delete();
    else begin
      if (popok) void'(q.pop_front());
      if (tk && (n < 16 || popok)) q.push_back(d);
    end
    @(posedge clk); #1;
    tick = 0; pop = 0; flush = 0; ovr_clr = 0;
    check_all();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_cnt"},   32'(count), 0);
    chk({tag, "_ovr"},   32'(overrun), 0);
    chk({tag, "_thr"},   32'(irq_thresh), 0);
    chk({tag, "_irq"},   32'(irq_ovr), 0);
  endtask

  initial begin
    rst = 1; tick = 0; din = 0; pop = 0; flush = 0; ovr_clr = 0; thresh = 0;
    m_ovr = 0; m_irq = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset("rst");

    // Two bytes 5 cycles apart, then drain.
    cyc(1, 8'hA5, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    cyc(1, 8'h3C, 0, 0, 0);
    chk("t1_cnt", 32'(count), 2);
    chk("t1_head", 32'(rd_data), 32'hA5);
    cyc(0, 0, 1, 0, 0);
    chk("t1_head2", 32'(rd_data), 32'h3C);
    chk("t1_cnt2", 32'(count), 1);
    cyc(0, 0, 1, 0, 0);
    chk("t1_empty", 32'(empty), 1);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t2_full", 32'(full), 1);
    chk("t2_cnt", 32'(count), 16);
    cyc(1, 8'hFF, 0, 0, 0);
    chk("t2_ovr", 32'(overrun), 1);
    chk("t2_irq", 32'(irq_ovr), 1);
    chk("t2_cnt2", 32'(count), 16);
    cyc(0, 0, 0, 0, 0);
    chk("t2_irq_once", 32'(irq_ovr), 0);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(rd_data), 32'(i));
      cyc(0, 0, 1, 0, 0);
    end
    chk("t2_empty", 32'(empty), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_clr", 32'(overrun), 0);

    // A push and a pop on a full FIFO, and again on an empty FIFO.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
    cyc(1, 8'h77, 1, 0, 0);
    chk("t3_cnt", 32'(count), 16);
    chk("t3_ovr", 32'(overrun), 0);
    chk("t3_head", 32'(rd_data), 32'h21);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0, 0);
    chk("t3_last", 32'(rd_data), 32'h77);
    cyc(0, 0, 1, 0, 0);
    chk("t3_empty", 32'(empty), 1);
    cyc(1, 8'h11, 1, 0, 0);
    chk("t3_cnt1", 32'(count), 1);
    chk("t3_head1", 32'(rd_data), 32'h11);
    cyc(0, 0, 1, 0, 0);

    // Threshold interrupt.
    thresh = 4;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
    chk("t4_thr3", 32'(irq_thresh), 0);
    cyc(1, 8'h53, 0, 0, 0);
    chk("t4_thr4", 32'(irq_thresh), 1);
    cyc(0, 0, 1, 0, 0);
    chk("t4_thr_pop", 32'(irq_thresh), 0);
    thresh = 0;
    for (int i = 0; i < 13; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
    chk("t4_cnt16", 32'(count), 16);
    chk("t4_thr_off", 32'(irq_thresh), 0);
    thresh = 17;
    #1 chk("t4_thr_big", 32'(irq_thresh), 0);
    thresh = 16;
    #1 chk("t4_thr_eq", 32'(irq_thresh), 1);
    thresh = 0;
    cyc(0, 0, 0, 1, 0);
    chk("t4_flush", 32'(count), 0);

    // Streaming with the pointers wrapping. The model is checked every cycle.
    for (int i = 0; i < 40; i++) cyc(1, 8'(8'h80 + i), (i % 4) != 0, 0, 0);
    while (q.size() > 0) cyc(0, 0, 1, 0, 0);
    chk("t5_empty", 32'(empty), 1);

    // Overrun set-vs-clear, then a flush with a same-cycle tick.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
    cyc(1, 8'hEE, 0, 0, 0);
    chk("t6_irq", 32'(irq_ovr), 1);
    cyc(1, 8'hEF, 0, 0, 1);
    chk("t6_setwins", 32'(overrun), 1);
    chk("t6_no_repulse", 32'(irq_ovr), 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0, 0);
    chk("t6_cnt5", 32'(count), 5);
    cyc(1, 8'h99, 0, 1, 0);
    chk("t6_fl_cnt", 32'(count), 0);
    chk("t6_fl_empty", 32'(empty), 1);
    chk("t6_fl_ovr", 32'(overrun), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t6_clr", 32'(overrun), 0);

    // Reset mid-stream.
    thresh = 2;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hD0 + i), 0, 0, 0);
    thresh = 0;
    rst = 1; tick = 1; din = 8'hAB;
    @(posedge clk); #1;
    rst = 0; tick = 0;
    q.delete(); m_ovr = 0; m_irq = 0;
    chk_reset("rst2");
    cyc(1, 8'h42, 0, 0, 0);
    chk("rst2_head", 32'(rd_data), 32'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
